// File: rtl/sync_asym_fifo_if.sv
// Handshake and status bundle for the width-converting synchronous FIFO.
// The FIFO takes the slave side; the producer/consumer logic takes master.
interface sync_asym_fifo_if #(
    parameter int WR_WIDTH = 8,
    parameter int RD_WIDTH = 32,
    parameter int CNT_W    = 6
);
    logic                wr_en;
    logic [WR_WIDTH-1:0] wr_data;
    logic                fifo_full;
    logic                almost_full;
    logic [CNT_W-1:0]    wr_data_count;
    logic                overflow;
    logic                rd_en;
    logic [RD_WIDTH-1:0] rd_data;
    logic                rd_valid;
    logic                fifo_empty;
    logic                almost_empty;
    logic [CNT_W-1:0]    rd_data_count;
    logic                underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  fifo_full, almost_full, wr_data_count, overflow,
        input  rd_data, rd_valid, fifo_empty, almost_empty,
        input  rd_data_count, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output fifo_full, almost_full, wr_data_count, overflow,
        output rd_data, rd_valid, fifo_empty, almost_empty,
        output rd_data_count, underflow
    );
endinterface

// File: rtl/sync_asym_fifo.sv
// Single-clock FIFO with independent write/read widths over a RAM of
// RAM_WIDTH-bit units; first-written unit lands in the LS slice.
module sync_asym_fifo #(
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int WR_WIDTH       = 8,
    parameter int RD_WIDTH       = 32,
    parameter int RAM_WIDTH      = 8,
    parameter int WR_IND         = 1,
    parameter int RD_IND         = 4,
    parameter int FWFT           = 1,
    parameter int AFULL_TH       = 28,
    parameter int AEMPTY_TH      = 4
) (
    input logic              clk,
    input logic              rst,
    sync_asym_fifo_if.slave  bus
);
    localparam int AW = RAM_ADDR_WIDTH;
    localparam int CW = RAM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] WI    = CW'(WR_IND);
    localparam logic [CW-1:0] RI    = CW'(RD_IND);
    localparam logic [CW-1:0] DEPTH = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AF    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE    = CW'(AEMPTY_TH);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] wr_cnt_q, rd_cnt_q;
    logic          full_q, afull_q;
    logic          empty_q, aempty_q;
    logic          ovf_q, unf_q;
    logic          wa, ra;
    logic [RD_WIDTH-1:0] head;

    assign wa = bus.wr_en & ~full_q;
    assign ra = bus.rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (wa ? WI : '0);
        rd_ptr_d = rd_ptr_q + (ra ? RI : '0);
        occ_d    = occ_q + (wa ? WI : '0) - (ra ? RI : '0);
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < RD_IND; i++) begin
            head[i*RAM_WIDTH +: RAM_WIDTH] =
                mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
        end
    end

    // Storage is never cleared; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (!rst && wa) begin
            for (int i = 0; i < WR_IND; i++) begin
                mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <=
                    bus.wr_data[i*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            wr_cnt_q <= occ_d / WI;
            rd_cnt_q <= occ_d / RI;
            full_q   <= (DEPTH - occ_d) < WI;
            afull_q  <= occ_d >= AF;
            empty_q  <= occ_d < RI;
            aempty_q <= occ_d <= AE;
            ovf_q    <= bus.wr_en & full_q;
            unf_q    <= bus.rd_en & empty_q;
        end
    end

    assign bus.fifo_full     = full_q;
    assign bus.almost_full   = afull_q;
    assign bus.wr_data_count = wr_cnt_q;
    assign bus.overflow      = ovf_q;
    assign bus.fifo_empty    = empty_q;
    assign bus.almost_empty  = aempty_q;
    assign bus.rd_data_count = rd_cnt_q;
    assign bus.underflow     = unf_q;

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; zero while no full word is stored.
        assign bus.rd_data  = empty_q ? '0 : head;
        assign bus.rd_valid = ~empty_q;
    end else begin : g_std
        logic [RD_WIDTH-1:0] rd_data_q;
        logic                rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= ra;
                if (ra) begin
                    rd_data_q <= head;
                end
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end
endmodule
